// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared widths and FSM state encodings for the L1 data cache
//
// Contents:
//   DCACHE_* defaults  address width, line size and line count of the stock cache
//   OFFSET_W           byte offset bits within a 32-byte line
//   INDEX_W / TAG_W    index and tag widths derived from the defaults
//   WORDS_PER_LINE     32-bit words per line
//   state_t + IDLE, WB_REQ, ALLOC_REQ, REFILL controller states
package dcache_pkg;

    localparam int DCACHE_ADDR_W     = 32;
    localparam int DCACHE_BLOCK_BITS = 256;
    localparam int DCACHE_NUM_LINES  = 16;

    localparam int OFFSET_W       = 5;
    localparam int INDEX_W        = $clog2(DCACHE_NUM_LINES);
    localparam int TAG_W          = DCACHE_ADDR_W - OFFSET_W - INDEX_W;
    localparam int WORDS_PER_LINE = 8;

    typedef logic [1:0] state_t;

    localparam state_t IDLE      = 2'd0;
    localparam state_t WB_REQ    = 2'd1;
    localparam state_t ALLOC_REQ = 2'd2;
    localparam state_t REFILL    = 2'd3;

endpackage

// File: rtl/dcache_sram.sv
// rtl/dcache_sram.sv - line storage (valid, dirty, tag, data) for the direct-mapped cache
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset, clears valid and dirty only
//   index      line selected for both read and write
//   rd_valid, rd_dirty, rd_tag, rd_data   combinational read of the selected line
//   word_we, word_sel, word_data          merge one 32-bit word, marks the line dirty
//   fill_we, fill_tag, fill_data          install a whole line, valid and clean
module dcache_sram
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = DCACHE_NUM_LINES,
    parameter int IDX_W      = INDEX_W,
    parameter int TAG_BITS   = TAG_W,
    parameter int BLOCK_BITS = DCACHE_BLOCK_BITS,
    parameter int SEL_W      = $clog2(WORDS_PER_LINE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [IDX_W-1:0]      index,
    output logic                  rd_valid,
    output logic                  rd_dirty,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [BLOCK_BITS-1:0] rd_data,
    input  logic                  word_we,
    input  logic [SEL_W-1:0]      word_sel,
    input  logic [31:0]           word_data,
    input  logic                  fill_we,
    input  logic [TAG_BITS-1:0]   fill_tag,
    input  logic [BLOCK_BITS-1:0] fill_data
);

    localparam int BASE_W = SEL_W + 5;

    logic [NUM_LINES-1:0]  valid_q;
    logic [NUM_LINES-1:0]  dirty_q;
    logic [TAG_BITS-1:0]   tag_q  [NUM_LINES];
    logic [BLOCK_BITS-1:0] data_q [NUM_LINES];

    logic [BASE_W-1:0] word_base;
    assign word_base = {word_sel, 5'b00000};

    // Status bits are the only state that must come out of reset clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill_we) begin
            valid_q[index] <= 1'b1;
            dirty_q[index] <= 1'b0;
        end else if (word_we) begin
            dirty_q[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_we) begin
            tag_q[index]  <= fill_tag;
            data_q[index] <= fill_data;
        end else if (word_we) begin
            data_q[index][word_base +: 32] <= word_data;
        end
    end

    assign rd_valid = valid_q[index];
    assign rd_dirty = dirty_q[index];
    assign rd_tag   = tag_q[index];
    assign rd_data  = data_q[index];

endmodule

// File: rtl/dcache_controller.sv
// rtl/dcache_controller.sv - direct-mapped write-back write-allocate L1 data cache controller
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   cpu_req_i, cpu_write_i       MEM-stage access valid, 1 = store
//   cpu_addr_i, cpu_wdata_i      word-aligned byte address, store data
//   cpu_rdata_o                  load data on a hit cycle, else 0
//   cpu_stall_o                  freezes the pipeline during a miss
//   mem_req_o, mem_write_o       block request, 1 = writeback, 0 = fetch
//   mem_addr_o, mem_wdata_o      block-aligned address, writeback line
//   mem_rdata_i, mem_ack_i       fetched line, one-cycle completion pulse
module dcache_controller
    import dcache_pkg::*;
#(
    parameter int NUM_LINES  = DCACHE_NUM_LINES,
    parameter int BLOCK_BITS = DCACHE_BLOCK_BITS,
    parameter int ADDR_W     = DCACHE_ADDR_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_write_i,
    input  logic [ADDR_W-1:0]     cpu_addr_i,
    input  logic [31:0]           cpu_wdata_i,
    output logic [31:0]           cpu_rdata_o,
    output logic                  cpu_stall_o,
    output logic                  mem_req_o,
    output logic                  mem_write_o,
    output logic [ADDR_W-1:0]     mem_addr_o,
    output logic [BLOCK_BITS-1:0] mem_wdata_o,
    input  logic [BLOCK_BITS-1:0] mem_rdata_i,
    input  logic                  mem_ack_i
);

    localparam int IDX_W  = $clog2(NUM_LINES);
    localparam int TG_W   = ADDR_W - OFFSET_W - IDX_W;
    localparam int SEL_W  = $clog2(WORDS_PER_LINE);
    localparam int BASE_W = SEL_W + 5;

    state_t state_q;
    state_t state_d;

    logic [TG_W-1:0]       req_tag;
    logic [IDX_W-1:0]      req_index;
    logic [SEL_W-1:0]      req_sel;
    logic [BASE_W-1:0]     word_base;

    logic                  rd_valid;
    logic                  rd_dirty;
    logic [TG_W-1:0]       rd_tag;
    logic [BLOCK_BITS-1:0] rd_data;

    logic [BLOCK_BITS-1:0] fill_buf_q;
    logic                  hit;
    logic                  word_we;
    logic                  fill_we;
    logic                  unused_addr_lsbs;

    assign req_tag          = cpu_addr_i[ADDR_W-1 -: TG_W];
    assign req_index        = cpu_addr_i[OFFSET_W +: IDX_W];
    assign req_sel          = cpu_addr_i[2 +: SEL_W];
    assign word_base        = {req_sel, 5'b00000};
    assign unused_addr_lsbs = ^cpu_addr_i[1:0];

    // The request is held stable through a miss, so the request index keeps
    // addressing the victim line for writeback and the refill target.
    dcache_sram #(
        .NUM_LINES  (NUM_LINES),
        .IDX_W      (IDX_W),
        .TAG_BITS   (TG_W),
        .BLOCK_BITS (BLOCK_BITS),
        .SEL_W      (SEL_W)
    ) u_sram (
        .clk       (clk_i),
        .rst       (rst_i),
        .index     (req_index),
        .rd_valid  (rd_valid),
        .rd_dirty  (rd_dirty),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .word_we   (word_we),
        .word_sel  (req_sel),
        .word_data (cpu_wdata_i),
        .fill_we   (fill_we),
        .fill_tag  (req_tag),
        .fill_data (fill_buf_q)
    );

    assign hit     = (state_q == IDLE) && cpu_req_i && rd_valid && (rd_tag == req_tag);
    assign word_we = hit && cpu_write_i;
    assign fill_we = (state_q == REFILL);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (state_q == ALLOC_REQ && mem_ack_i) begin
            fill_buf_q <= mem_rdata_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                // An invalid line is never written back, whatever its dirty bit says.
                if (cpu_req_i && !hit) begin
                    state_d = (rd_valid && rd_dirty) ? WB_REQ : ALLOC_REQ;
                end
            end
            WB_REQ:    if (mem_ack_i) state_d = ALLOC_REQ;
            ALLOC_REQ: if (mem_ack_i) state_d = REFILL;
            REFILL:    state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        case (state_q)
            WB_REQ: begin
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = {rd_tag, req_index, {OFFSET_W{1'b0}}};
                mem_wdata_o = rd_data;
            end
            ALLOC_REQ: begin
                mem_req_o  = 1'b1;
                mem_addr_o = {req_tag, req_index, {OFFSET_W{1'b0}}};
            end
            default: ;
        endcase
    end

    assign cpu_stall_o = (state_q != IDLE) || (cpu_req_i && !hit);
    assign cpu_rdata_o = hit ? rd_data[word_base +: 32] : 32'd0;

    a_cpu_hold: assert property (@(posedge clk_i) disable iff (rst_i)
        cpu_stall_o |=> ($stable(cpu_req_i) && $stable(cpu_write_i) &&
                         $stable(cpu_addr_i) && $stable(cpu_wdata_i)));

    a_word_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
        cpu_req_i |-> (cpu_addr_i[1:0] == 2'b00));

endmodule

// File: tb/tb_dcache_controller.sv
// tb/tb_dcache_controller.sv - self-checking bench for dcache_controller
module tb_dcache_controller;

    localparam int ACK_DELAY = 10;
    localparam int CLEAN_LAT = ACK_DELAY + 3;
    localparam int DIRTY_LAT = 2 * ACK_DELAY + 5;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [255:0] data;
    } txn_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cpu_req = 1'b0;
    logic         cpu_write = 1'b0;
    logic [31:0]  cpu_addr = '0;
    logic [31:0]  cpu_wdata = '0;
    logic [31:0]  cpu_rdata;
    logic         cpu_stall;
    logic         mem_req;
    logic         mem_write;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata;
    logic [255:0] mem_rdata = '0;
    logic         mem_ack = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;
    int hold_err = 0;

    logic [31:0]  ref_mem [logic [31:0]];
    logic [255:0] bmem    [logic [31:0]];
    logic [31:0]  rd_q[$];
    txn_t         txn_log[$];
    txn_t         exp_txn[$];

    always #5 clk = ~clk;

    dcache_controller dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .cpu_req_i   (cpu_req),
        .cpu_write_i (cpu_write),
        .cpu_addr_i  (cpu_addr),
        .cpu_wdata_i (cpu_wdata),
        .cpu_rdata_o (cpu_rdata),
        .cpu_stall_o (cpu_stall),
        .mem_req_o   (mem_req),
        .mem_write_o (mem_write),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    function automatic logic [31:0] init_word(input logic [31:0] a);
        if (a[31:5] == 27'd2)
            return 32'h1111_1111 * ({29'd0, a[4:2]} + 32'd1);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [255:0] ref_block(input logic [31:0] base);
        logic [255:0] b;
        for (int i = 0; i < 8; i++) b[32*i +: 32] = ref_word(base + 32'(4*i));
        return b;
    endfunction

    function automatic logic [255:0] get_block(input logic [31:0] base);
        logic [255:0] b;
        if (bmem.exists(base)) return bmem[base];
        for (int i = 0; i < 8; i++) b[32*i +: 32] = init_word(base + 32'(4*i));
        return b;
    endfunction

    // Memory model: acks ACK_DELAY cycles after a request is first seen,
    // abandons a request that drops, and flags any change of a held request.
    initial begin
        int cnt;
        logic         l_wr;
        logic [31:0]  l_addr;
        logic [255:0] l_wdata;
        cnt = 0;
        l_wr = 1'b0;
        l_addr = '0;
        l_wdata = '0;
        forever begin
            @(negedge clk);
            if (mem_ack) begin
                mem_ack = 1'b0;
                mem_rdata = '0;
                cnt = 0;
            end else if (mem_req === 1'b1) begin
                if (cnt == 0) begin
                    l_wr = mem_write;
                    l_addr = mem_addr;
                    l_wdata = mem_wdata;
                end else if (mem_write !== l_wr || mem_addr !== l_addr || mem_wdata !== l_wdata) begin
                    hold_err++;
                end
                if (cnt == ACK_DELAY) begin
                    mem_ack = 1'b1;
                    if (mem_write) begin
                        bmem[mem_addr] = mem_wdata;
                        txn_log.push_back('{1'b1, mem_addr, mem_wdata});
                    end else begin
                        mem_rdata = get_block(mem_addr);
                        txn_log.push_back('{1'b0, mem_addr, 256'd0});
                    end
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Issues one CPU access, waits for the stall to clear, then scores latency,
    // load data and the memory transactions that the access produced.
    task automatic cpu_access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int exp_lat, input string name);
        int cycles;
        logic [31:0] exp_rd;
        if (!wr) rd_q.push_back(ref_word(addr));
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_write = wr;
        cpu_addr = addr;
        cpu_wdata = wdata;
        #1;
        cycles = 0;
        while (cpu_stall === 1'b1 && cycles < 200) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        total_cnt++;
        if (cycles !== exp_lat) $display("FAIL %s latency: got %0d want %0d", name, cycles, exp_lat);
        else pass_cnt++;
        if (!wr) begin
            exp_rd = rd_q.pop_front();
            total_cnt++;
            if (cpu_rdata !== exp_rd) $display("FAIL %s rdata: got %h want %h", name, cpu_rdata, exp_rd);
            else pass_cnt++;
        end else begin
            ref_mem[addr] = wdata;
        end
        total_cnt++;
        if (txn_log.size() != exp_txn.size()) begin
            $display("FAIL %s txn count: got %0d want %0d", name, txn_log.size(), exp_txn.size());
        end else begin
            pass_cnt++;
            foreach (exp_txn[i]) begin
                total_cnt++;
                if (txn_log[i].wr !== exp_txn[i].wr || txn_log[i].addr !== exp_txn[i].addr ||
                    txn_log[i].data !== exp_txn[i].data)
                    $display("FAIL %s txn%0d: got wr=%0b addr=%h want wr=%0b addr=%h (or data differs)",
                             name, i, txn_log[i].wr, txn_log[i].addr, exp_txn[i].wr, exp_txn[i].addr);
                else pass_cnt++;
            end
        end
        txn_log.delete();
        exp_txn.delete();
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        cpu_write = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        total_cnt++;
        if (cpu_stall !== 1'b0 || mem_req !== 1'b0 || mem_write !== 1'b0)
            $display("FAIL reset ctrl: got stall=%b req=%b wr=%b want 0 0 0", cpu_stall, mem_req, mem_write);
        else pass_cnt++;
        total_cnt++;
        if (mem_addr !== 32'd0 || mem_wdata !== 256'd0 || cpu_rdata !== 32'd0)
            $display("FAIL reset data: got addr=%h rdata=%h want 0", mem_addr, cpu_rdata);
        else pass_cnt++;
        total_cnt++;
        if (dut.u_sram.valid_q !== 16'd0 || dut.u_sram.dirty_q !== 16'd0)
            $display("FAIL reset status: got valid=%h dirty=%h want 0", dut.u_sram.valid_q, dut.u_sram.dirty_q);
        else pass_cnt++;
    endtask

    task automatic test_cold_miss();
        exp_txn.push_back('{1'b0, 32'h40, 256'd0});
        cpu_access(1'b0, 32'h40, 32'd0, CLEAN_LAT, "cold_miss");
    endtask

    task automatic test_read_hit();
        @(negedge clk);
        #1;
        cpu_access(1'b0, 32'h44, 32'd0, 0, "read_hit");
        total_cnt++;
        if (mem_req !== 1'b0) $display("FAIL read_hit mem_req: got %b want 0", mem_req);
        else pass_cnt++;
    endtask

    task automatic test_write_hit();
        cpu_access(1'b1, 32'h48, 32'hDEAD_BEEF, 0, "write_hit");
        total_cnt++;
        if (dut.u_sram.dirty_q[2] !== 1'b1) $display("FAIL write_hit dirty2: got %b want 1", dut.u_sram.dirty_q[2]);
        else pass_cnt++;
        cpu_access(1'b0, 32'h48, 32'd0, 0, "write_hit_readback");
    endtask

    task automatic test_dirty_evict();
        exp_txn.push_back('{1'b1, 32'h40, ref_block(32'h40)});
        exp_txn.push_back('{1'b0, 32'h240, 256'd0});
        cpu_access(1'b0, 32'h240, 32'd0, DIRTY_LAT, "dirty_evict");
        total_cnt++;
        if (dut.u_sram.dirty_q[2] !== 1'b0) $display("FAIL dirty_evict dirty2: got %b want 0", dut.u_sram.dirty_q[2]);
        else pass_cnt++;
    endtask

    task automatic test_store_miss();
        exp_txn.push_back('{1'b0, 32'h1000, 256'd0});
        cpu_access(1'b1, 32'h1000, 32'hCAFE_F00D, CLEAN_LAT, "store_miss");
        total_cnt++;
        if (dut.u_sram.dirty_q[0] !== 1'b1) $display("FAIL store_miss dirty0: got %b want 1", dut.u_sram.dirty_q[0]);
        else pass_cnt++;
        cpu_access(1'b0, 32'h1000, 32'd0, 0, "store_miss_readback");
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i < 4; i++)
            cpu_access(1'b1, 32'h1000 + 32'(4*i), $urandom, 0, "b2b_store");
        for (int i = 0; i < 4; i++)
            cpu_access(1'b0, 32'h1000 + 32'(4*i), 32'd0, 0, "b2b_load");
    endtask

    task automatic test_reset_mid();
        exp_txn.push_back('{1'b0, 32'h40, 256'd0});
        cpu_access(1'b0, 32'h40, 32'd0, CLEAN_LAT, "refetch_40");
        // Start a clean miss to 0x1040 (index 2) and reset it part way through ALLOC_REQ.
        @(negedge clk);
        cpu_req = 1'b1;
        cpu_write = 1'b0;
        cpu_addr = 32'h1040;
        repeat (3) @(negedge clk);
        #1;
        total_cnt++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h1040)
            $display("FAIL reset_mid alloc: got req=%b addr=%h want 1 00001040", mem_req, mem_addr);
        else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        #1;
        total_cnt++;
        if (mem_req !== 1'b0) $display("FAIL reset_mid mem_req: got %b want 0", mem_req);
        else pass_cnt++;
        cpu_req = 1'b0;
        #1;
        total_cnt++;
        if (cpu_stall !== 1'b0) $display("FAIL reset_mid stall: got %b want 0", cpu_stall);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        txn_log.delete();
        exp_txn.push_back('{1'b0, 32'h40, 256'd0});
        cpu_access(1'b0, 32'h40, 32'd0, CLEAN_LAT, "after_reset_miss");
    endtask

    task automatic test_hold();
        total_cnt++;
        if (hold_err != 0) $display("FAIL mem_hold: got %0d changes want 0", hold_err);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_read_hit();
        test_write_hit();
        test_dirty_evict();
        test_store_miss();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
